ex_mem_access_stage: RTL and testbench
======================================

Name: ex_mem_access_stage

Overview:
Combined ALU-control decoder and registered memory-access stage for the 64-bit LEGv8-style pipelined CPU, sitting between Execute and Write-back. The combinational decoder turns the instruction opcode plus the 2-bit ALUOp into the 4-bit ALU operation code consumed by Execute. The registered MEM section resolves branches, performs data-memory loads and stores on an internal word-addressed RAM, and produces write-back data and destination register.

Parameters:
MEM_WORDS, 128, number of 64-bit data-memory words; power of two, minimum 2.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
instr_i  in  32  instruction in this stage; [31:21] opcode, [4:0] Rd/Rt
alu_op_i  in  2  ALUOp from main control
alu_ctrl_o  out  4  decoded ALU operation (combinational)
branch_addr_i  in  64  computed branch target
alu_result_i  in  64  ALU result; byte address for load/store
wr_data_i  in  64  store data (register Rt value)
zero_i  in  1  ALU zero flag
b_i / bz_i / bnz_i  in  1 each  unconditional / CBZ / CBNZ
mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i  in  1 each  control bits
branch_addr_o  out  64  registered branch target
pc_src_o  out  1  registered take-branch
reg_write_o  out  1  registered RegWrite
wb_data_o  out  64  write-back data
wb_reg_o  out  5  write-back register number

Behaviour:
- Clocking: one clock domain on clk; reset is asynchronous and active-low on rst_n. No clock gating.
- ALU control is purely combinational, with no reset dependence:
  - alu_op_i=00 -> 0010 (add; LDUR/STUR).
  - 01 -> 0111 (pass input B; CBZ/CBNZ).
  - 10 (R-type), opcode instr_i[31:21]:
    - 10001011000 ADD -> 0010
    - 11001011000 SUB -> 0110
    - 10001010000 AND -> 0000
    - 10101010000 ORR -> 0001
  - 11 (I-type), opcode instr_i[31:22]:
    - 1001000100 ADDI -> 0010
    - 1101000100 SUBI -> 0110
    - 1001001000 ANDI -> 0000
    - 1011001000 ORRI -> 0001
  - Any unmatched opcode -> 1111 (invalid).
- Branch resolution: pc_src = b_i | (bz_i & zero_i) | (bnz_i & ~zero_i).
- On each rising clk (rst_n high), register:
  - pc_src_o
  - branch_addr_o <= branch_addr_i
  - reg_write_o <= reg_write_i
  - wb_reg_o <= instr_i[4:0]
- Memory addressing: word index = alu_result_i[3+log2(MEM_WORDS)-1:3]. Bits [2:0] are ignored (misaligned addresses are truncated). Higher bits are ignored, so addresses wrap modulo MEM_WORDS*8.
- Store: if mem_write_i=1 at the edge, mem[index] <= wr_data_i.
- Load: synchronous read at the same edge.
- Write-back data: wb_data_o <= mem_to_reg_i ? mem[index] : alu_result_i. Latency is 1 cycle for all outputs except alu_ctrl_o.
- mem_read_i and mem_write_i both 1: the write is performed and the read returns the pre-write contents (read-before-write).
- mem_read_i=0 with mem_to_reg_i=1: the read is still performed and memory data is selected (mem_read_i only gates an internal read enable; it has no effect on the result).
- Reset (async assert): pc_src_o=0, branch_addr_o=0, reg_write_o=0, wb_data_o=0, wb_reg_o=0. Memory contents are not cleared. Any store presented in the reset cycle is dropped.
- Reset released mid-stream: the first rising edge after rst_n rises samples the inputs normally.

Optional Feature:
MEM_ACCESS_ERR_EN:
- Defined: adds output err_o (1 bit, registered, reset 0).
- err_o is set for one cycle when:
  - alu_ctrl_o was 1111 while alu_op_i=10 or 11, or
  - a load or store had alu_result_i[2:0] != 0, or
  - alu_result_i addressed beyond MEM_WORDS*8.
- Undefined: the port does not exist and these conditions are silently ignored.

Test Plan:
- Decode: alu_op_i=10 with opcodes ADD, SUB, AND, ORR -> alu_ctrl_o 0010, 0110, 0000, 0001; alu_op_i=00 -> 0010; 01 -> 0111; 11 with ADDI 1001000100 -> 0010; unknown opcode 11111111111 with alu_op_i=10 -> 1111.
- Store/load:
  - Cycle 1: mem_write_i=1, alu_result_i=0x10, wr_data_i=0xDEADBEEF.
  - Next cycle: mem_read_i=1, mem_to_reg_i=1, addr 0x10.
  - Required: wb_data_o=0xDEADBEEF one cycle later; addr 0x13 returns the same word.
- Branches (branch_addr_i=0x400):
  - bz_i=1, zero_i=1 -> pc_src_o=1, branch_addr_o=0x400 next cycle.
  - bz_i=1, zero_i=0 -> pc_src_o=0.
  - bnz_i=1, zero_i=0 -> pc_src_o=1.
  - b_i=1 -> pc_src_o=1 regardless of zero_i.
- R-type writeback: mem_to_reg_i=0, reg_write_i=1, alu_result_i=42, instr_i[4:0]=7 -> wb_data_o=42, wb_reg_o=7, reg_write_o=1.
- Wrap and simultaneous access (MEM_WORDS=128):
  - Store 5 at addr 0x408 -> load from 0x008 returns 5.
  - Read+write same cycle returns the old value.
- Reset: assert rst_n=0 asynchronously mid-cycle with outputs nonzero -> all outputs 0 immediately; previously stored memory data is still readable after release.

Source files
------------

// File: rtl/ex_mem_access_stage.sv
// Combinational ALU-control decoder plus registered MEM stage (branch resolve, data RAM, write-back).
// Optional MEM_ACCESS_ERR_EN adds a registered err_o flag for bad decode / misaligned / out-of-range accesses.
module ex_mem_access_stage #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic [1:0]  alu_op_i,
  output logic [3:0]  alu_ctrl_o,
  input  logic [63:0] branch_addr_i,
  input  logic [63:0] alu_result_i,
  input  logic [63:0] wr_data_i,
  input  logic        zero_i,
  input  logic        b_i,
  input  logic        bz_i,
  input  logic        bnz_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        mem_to_reg_i,
  input  logic        reg_write_i,
  output logic [63:0] branch_addr_o,
  output logic        pc_src_o,
  output logic        reg_write_o,
  output logic [63:0] wb_data_o,
`ifdef MEM_ACCESS_ERR_EN
  output logic        err_o,
`endif
  output logic [4:0]  wb_reg_o
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_INVAL = 4'b1111;

  logic [3:0] alu_ctrl;

  always_comb begin
    // NOTE: default assignment first so every path drives alu_ctrl and no latch is inferred.
    alu_ctrl = ALU_INVAL;
    case (alu_op_i)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_PASSB;
      2'b10: begin
        case (instr_i[31:21])
          OP_ADD:  alu_ctrl = ALU_ADD;
          OP_SUB:  alu_ctrl = ALU_SUB;
          OP_AND:  alu_ctrl = ALU_AND;
          OP_ORR:  alu_ctrl = ALU_ORR;
          default: alu_ctrl = ALU_INVAL;
        endcase
      end
      default: begin
        case (instr_i[31:22])
          OP_ADDI: alu_ctrl = ALU_ADD;
          OP_SUBI: alu_ctrl = ALU_SUB;
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORRI: alu_ctrl = ALU_ORR;
          default: alu_ctrl = ALU_INVAL;
        endcase
      end
    endcase
  end

  assign alu_ctrl_o = alu_ctrl;

  // Immediate/register fields between the opcode and Rd are not needed in this stage.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_i[20:5];

  // Word index drops the byte offset and any bits above the RAM size, so addresses wrap.
  logic [AW-1:0] mem_idx;
  logic [63:0]   mem_q [MEM_WORDS];
  logic          rd_en;
  logic [63:0]   rd_word;

  assign mem_idx = alu_result_i[AW+2:3];
  assign rd_en   = mem_read_i | mem_to_reg_i;
  assign rd_word = rd_en ? mem_q[mem_idx] : 64'd0;

  // NOTE: the RAM has no reset; contents survive rst_n, and gating on rst_n drops stores during reset.
  always_ff @(posedge clk) begin
    if (rst_n && mem_write_i) mem_q[mem_idx] <= wr_data_i;
  end

  logic        pc_src_d,      pc_src_q;
  logic [63:0] branch_addr_q;
  logic        reg_write_q;
  logic [63:0] wb_data_d,     wb_data_q;
  logic [4:0]  wb_reg_q;

  assign pc_src_d  = b_i | (bz_i & zero_i) | (bnz_i & ~zero_i);
  assign wb_data_d = mem_to_reg_i ? rd_word : alu_result_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_src_q      <= 1'b0;
      branch_addr_q <= 64'd0;
      reg_write_q   <= 1'b0;
      wb_data_q     <= 64'd0;
      wb_reg_q      <= 5'd0;
    end else begin
      pc_src_q      <= pc_src_d;
      branch_addr_q <= branch_addr_i;
      reg_write_q   <= reg_write_i;
      wb_data_q     <= wb_data_d;
      wb_reg_q      <= instr_i[4:0];
    end
  end

  assign pc_src_o      = pc_src_q;
  assign branch_addr_o = branch_addr_q;
  assign reg_write_o   = reg_write_q;
  assign wb_data_o     = wb_data_q;
  assign wb_reg_o      = wb_reg_q;

`ifdef MEM_ACCESS_ERR_EN
  logic mem_access;
  logic err_d, err_q;

  assign mem_access = mem_read_i | mem_write_i;
  assign err_d = (alu_op_i[1] && (alu_ctrl == ALU_INVAL))
               | (mem_access && (alu_result_i[2:0] != 3'd0))
               | (mem_access && (|alu_result_i[63:AW+3]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_ex_mem_access_stage.sv
// Self-checking bench for ex_mem_access_stage: directed scenarios plus randomized traffic
// compared against a word-array memory model and an opcode lookup table.
module tb_ex_mem_access_stage;

  localparam int WORDS = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_i;
  logic [1:0]  alu_op_i;
  logic [3:0]  alu_ctrl_o;
  logic [63:0] branch_addr_i, alu_result_i, wr_data_i;
  logic        zero_i, b_i, bz_i, bnz_i;
  logic        mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i;
  logic [63:0] branch_addr_o;
  logic        pc_src_o, reg_write_o;
  logic [63:0] wb_data_o;
  logic [4:0]  wb_reg_o;
`ifdef MEM_ACCESS_ERR_EN
  logic        err_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] model_mem [WORDS];
  bit [3:0] r_map [bit [10:0]];
  bit [3:0] i_map [bit [9:0]];

  ex_mem_access_stage #(.MEM_WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .alu_op_i(alu_op_i),
    .alu_ctrl_o(alu_ctrl_o), .branch_addr_i(branch_addr_i),
    .alu_result_i(alu_result_i), .wr_data_i(wr_data_i), .zero_i(zero_i),
    .b_i(b_i), .bz_i(bz_i), .bnz_i(bnz_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
    .reg_write_i(reg_write_i), .branch_addr_o(branch_addr_o),
    .pc_src_o(pc_src_o), .reg_write_o(reg_write_o), .wb_data_o(wb_data_o),
`ifdef MEM_ACCESS_ERR_EN
    .err_o(err_o),
`endif
    .wb_reg_o(wb_reg_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Reference decode: lookup of mnemonic opcodes, anything else is invalid.
  function automatic logic [3:0] ref_alu_ctrl(input logic [1:0] op, input logic [31:0] ins);
    bit [10:0] r_op = ins[31:21];
    bit [9:0]  i_op = ins[31:22];
    if (op == 2'd0) return 4'b0010;
    if (op == 2'd1) return 4'b0111;
    if (op == 2'd2) return r_map.exists(r_op) ? r_map[r_op] : 4'b1111;
    return i_map.exists(i_op) ? i_map[i_op] : 4'b1111;
  endfunction

  function automatic int word_of(input logic [63:0] addr);
    return int'((addr % 64'(WORDS * 8)) / 64'd8);
  endfunction

  task automatic idle();
    instr_i = 32'd0; alu_op_i = 2'd0; branch_addr_i = 64'd0; alu_result_i = 64'd0;
    wr_data_i = 64'd0; zero_i = 1'b0; b_i = 1'b0; bz_i = 1'b0; bnz_i = 1'b0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; mem_to_reg_i = 1'b0; reg_write_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (pc_src_o !== 1'b0) begin n_fail++; $display("FAIL reset_pc_src got %b want 0", pc_src_o); end
    n_checks++; if (branch_addr_o !== 64'd0) begin n_fail++; $display("FAIL reset_branch_addr got %h want 0", branch_addr_o); end
    n_checks++; if (reg_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write got %b want 0", reg_write_o); end
    n_checks++; if (wb_data_o !== 64'd0) begin n_fail++; $display("FAIL reset_wb_data got %h want 0", wb_data_o); end
    n_checks++; if (wb_reg_o !== 5'd0) begin n_fail++; $display("FAIL reset_wb_reg got %0d want 0", wb_reg_o); end
`ifdef MEM_ACCESS_ERR_EN
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_o); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [1:0]  ops  [8] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd2};
    logic [10:0] opc  [8] = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
                              11'b10101010000, 11'b11111111111, 11'b11111111111,
                              11'b10010001000, 11'b11111111111};
    logic [3:0]  want [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0111,
                              4'b0010, 4'b1111};
    bit [10:0] r_keys [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    bit [9:0]  i_keys [4] = '{10'b1001000100, 10'b1101000100, 10'b1001001000, 10'b1011001000};
    logic [3:0] exp;
    for (int k = 0; k < 8; k++) begin
      alu_op_i = ops[k];
      instr_i  = {opc[k], 21'($urandom)};
      #1;
      n_checks++;
      if (alu_ctrl_o !== want[k]) begin
        n_fail++; $display("FAIL decode_dir%0d got %b want %b", k, alu_ctrl_o, want[k]);
      end
    end
    for (int k = 0; k < 200; k++) begin
      alu_op_i = 2'($urandom);
      instr_i  = $urandom;
      case ($urandom_range(0, 2))
        0: instr_i[31:21] = r_keys[$urandom_range(0, 3)];
        1: instr_i[31:22] = i_keys[$urandom_range(0, 3)];
        default: ;
      endcase
      exp = ref_alu_ctrl(alu_op_i, instr_i);
      #1;
      n_checks++;
      if (alu_ctrl_o !== exp) begin
        n_fail++; $display("FAIL decode_rand op=%b instr=%h got %b want %b", alu_op_i, instr_i, alu_ctrl_o, exp);
      end
    end
    idle();
  endtask

  task automatic test_store_load();
    idle();
    mem_write_i = 1'b1; alu_result_i = 64'h10; wr_data_i = 64'hDEADBEEF;
    tick();
    model_mem[word_of(64'h10)] = 64'hDEADBEEF;
    idle();
    mem_read_i = 1'b1; mem_to_reg_i = 1'b1; alu_result_i = 64'h10;
    tick();
    n_checks++; if (wb_data_o !== 64'hDEADBEEF) begin n_fail++; $display("FAIL load_0x10 got %h want deadbeef", wb_data_o); end
    alu_result_i = 64'h13;
    tick();
    n_checks++; if (wb_data_o !== 64'hDEADBEEF) begin n_fail++; $display("FAIL load_0x13 got %h want deadbeef", wb_data_o); end
    idle();
  endtask

  task automatic test_branch();
    logic [2:0] flg  [5] = '{3'b010, 3'b010, 3'b001, 3'b100, 3'b100}; // {b, bz, bnz}
    logic       zr   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       want [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      idle();
      branch_addr_i = 64'h400;
      {b_i, bz_i, bnz_i} = flg[k];
      zero_i = zr[k];
      tick();
      n_checks++; if (pc_src_o !== want[k]) begin n_fail++; $display("FAIL branch%0d pc_src got %b want %b", k, pc_src_o, want[k]); end
      n_checks++; if (branch_addr_o !== 64'h400) begin n_fail++; $display("FAIL branch%0d addr got %h want 400", k, branch_addr_o); end
    end
    idle();
  endtask

  task automatic test_rtype_wb();
    idle();
    reg_write_i = 1'b1; alu_result_i = 64'd42; instr_i = {27'($urandom), 5'd7};
    tick();
    n_checks++; if (wb_data_o !== 64'd42) begin n_fail++; $display("FAIL rtype_wb_data got %0d want 42", wb_data_o); end
    n_checks++; if (wb_reg_o !== 5'd7) begin n_fail++; $display("FAIL rtype_wb_reg got %0d want 7", wb_reg_o); end
    n_checks++; if (reg_write_o !== 1'b1) begin n_fail++; $display("FAIL rtype_reg_write got %b want 1", reg_write_o); end
    idle();
  endtask

  task automatic test_wrap_rmw();
    idle();
    mem_write_i = 1'b1; alu_result_i = 64'h408; wr_data_i = 64'd5;
    tick();
    idle();
    mem_read_i = 1'b1; mem_to_reg_i = 1'b1; alu_result_i = 64'h008;
    tick();
    n_checks++; if (wb_data_o !== 64'd5) begin n_fail++; $display("FAIL wrap_load got %h want 5", wb_data_o); end
    mem_write_i = 1'b1; wr_data_i = 64'd9;
    tick();
    n_checks++; if (wb_data_o !== 64'd5) begin n_fail++; $display("FAIL rmw_old got %h want 5", wb_data_o); end
    mem_write_i = 1'b0; mem_read_i = 1'b0;
    tick();
    n_checks++; if (wb_data_o !== 64'd9) begin n_fail++; $display("FAIL rmw_new got %h want 9", wb_data_o); end
    model_mem[1] = 64'd9;
    idle();
  endtask

  task automatic test_random();
    logic [63:0] e_wb;
    logic        e_pc;
    for (int w = 0; w < WORDS; w++) begin
      idle();
      mem_write_i  = 1'b1;
      alu_result_i = 64'(w * 8);
      wr_data_i    = {$urandom, $urandom};
      model_mem[w] = wr_data_i;
      tick();
    end
    for (int k = 0; k < 400; k++) begin
      instr_i       = $urandom;
      alu_op_i      = 2'($urandom);
      branch_addr_i = {$urandom, $urandom};
      alu_result_i  = {$urandom, $urandom};
      wr_data_i     = {$urandom, $urandom};
      {zero_i, b_i, bz_i, bnz_i} = 4'($urandom);
      {mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i} = 4'($urandom);
      e_pc = b_i || (bz_i && zero_i) || (bnz_i && !zero_i);
      e_wb = mem_to_reg_i ? model_mem[word_of(alu_result_i)] : alu_result_i;
      if (mem_write_i) model_mem[word_of(alu_result_i)] = wr_data_i;
      tick();
      n_checks++; if (pc_src_o !== e_pc) begin n_fail++; $display("FAIL rand%0d pc_src got %b want %b", k, pc_src_o, e_pc); end
      n_checks++; if (branch_addr_o !== branch_addr_i) begin n_fail++; $display("FAIL rand%0d branch_addr got %h want %h", k, branch_addr_o, branch_addr_i); end
      n_checks++; if (reg_write_o !== reg_write_i) begin n_fail++; $display("FAIL rand%0d reg_write got %b want %b", k, reg_write_o, reg_write_i); end
      n_checks++; if (wb_reg_o !== instr_i[4:0]) begin n_fail++; $display("FAIL rand%0d wb_reg got %0d want %0d", k, wb_reg_o, instr_i[4:0]); end
      n_checks++; if (wb_data_o !== e_wb) begin n_fail++; $display("FAIL rand%0d wb_data got %h want %h", k, wb_data_o, e_wb); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    mem_write_i = 1'b1; alu_result_i = 64'h20; wr_data_i = 64'hCAFE;
    tick();
    idle();
    b_i = 1'b1; branch_addr_i = 64'h400; reg_write_i = 1'b1;
    alu_result_i = 64'd42; instr_i = 32'd3;
    tick();
    n_checks++; if (pc_src_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre pc_src got %b want 1", pc_src_o); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pc_src_o !== 1'b0) begin n_fail++; $display("FAIL arst pc_src got %b want 0", pc_src_o); end
    n_checks++; if (branch_addr_o !== 64'd0) begin n_fail++; $display("FAIL arst branch_addr got %h want 0", branch_addr_o); end
    n_checks++; if (reg_write_o !== 1'b0) begin n_fail++; $display("FAIL arst reg_write got %b want 0", reg_write_o); end
    n_checks++; if (wb_data_o !== 64'd0) begin n_fail++; $display("FAIL arst wb_data got %h want 0", wb_data_o); end
    n_checks++; if (wb_reg_o !== 5'd0) begin n_fail++; $display("FAIL arst wb_reg got %0d want 0", wb_reg_o); end
    idle();
    mem_write_i = 1'b1; alu_result_i = 64'h20; wr_data_i = 64'hBAD;
    tick();
    n_checks++; if (wb_data_o !== 64'd0) begin n_fail++; $display("FAIL arst_hold wb_data got %h want 0", wb_data_o); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    mem_read_i = 1'b1; mem_to_reg_i = 1'b1; alu_result_i = 64'h20; instr_i = 32'd11;
    tick();
    n_checks++; if (wb_data_o !== 64'hCAFE) begin n_fail++; $display("FAIL arst_mem_kept got %h want cafe", wb_data_o); end
    n_checks++; if (wb_reg_o !== 5'd11) begin n_fail++; $display("FAIL arst_first_edge wb_reg got %0d want 11", wb_reg_o); end
    idle();
  endtask

  initial begin
    r_map[11'b10001011000] = 4'b0010;
    r_map[11'b11001011000] = 4'b0110;
    r_map[11'b10001010000] = 4'b0000;
    r_map[11'b10101010000] = 4'b0001;
    i_map[10'b1001000100]  = 4'b0010;
    i_map[10'b1101000100]  = 4'b0110;
    i_map[10'b1001001000]  = 4'b0000;
    i_map[10'b1011001000]  = 4'b0001;
    test_reset();
    test_decode();
    test_store_load();
    test_branch();
    test_rtype_wb();
    test_wrap_rmw();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
